// File: rtl/ram_if_pkg.sv
`default_nettype none
// =============================================================================
// Module      : ram_if_pkg
// Description : Shared definitions for the cache/RAM burst protocol responder.
// Revision    : 1.0 - initial release
// =============================================================================
package ram_if_pkg;

    localparam int BURST_LOG2 = 3;
    localparam int BURST_LEN  = 1 << BURST_LOG2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_FILL   = 3'd1,
        ST_RD_STREAM = 3'd2,
        ST_WR_ACCESS = 3'd3,
        ST_WR_HOLD   = 3'd4,
        ST_RECOVER   = 3'd5
    } state_t;

    // Clears the word-in-line bits so a fill always starts at word 0.
    function automatic logic [63:0] line_align(input logic [63:0] addr, input int log2);
        return addr & ~((64'd1 << log2) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_line_buffer.sv
`default_nettype none
// =============================================================================
// Module      : ram_line_buffer
// Description : One-line register file, single write port, asynchronous read.
// Revision    : 1.0 - initial release
// =============================================================================
module ram_line_buffer #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];

    // Contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/ram_burst_responder.sv
`default_nettype none
// =============================================================================
// Module      : ram_burst_responder
// Description : RAM side of the readram/writeram/ready burst protocol driving
//               an asynchronous SRAM; 8-word line fills and single-word writes.
// Revision    : 1.0 - initial release
// =============================================================================
module ram_burst_responder #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int BURST_LOG2  = ram_if_pkg::BURST_LOG2,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [ADDR_W-1:0] address_ram,
    input  logic [DATA_W-1:0] datatoram,
    input  logic              readram,
    input  logic              writeram,
    output logic [DATA_W-1:0] datafromram,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_dq_o,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_n_ce,
    output logic              sram_n_oe,
    output logic              sram_n_we
);

    import ram_if_pkg::*;

    localparam int                    WAIT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(WAIT_STATES);
    localparam logic [BURST_LOG2-1:0] IDX_LAST  = '1;

    state_t                  state_q, state_d;
    logic [BURST_LOG2-1:0]   idx_q, idx_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    ready_q, ready_d;
    logic [DATA_W-1:0]       dfr_q, dfr_d;
    logic [ADDR_W-1:0]       sram_a_q, sram_a_d;
    logic [DATA_W-1:0]       dq_o_q, dq_o_d;
    logic                    dq_oe_q, dq_oe_d;
    logic                    n_ce_q, n_ce_d;
    logic                    n_oe_q, n_oe_d;
    logic                    n_we_q, n_we_d;

    logic                    buf_we;
    logic [DATA_W-1:0]       buf_rdata;

    ram_line_buffer #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (BURST_LOG2)
    ) u_line_buffer (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (idx_q),
        .wdata_i (sram_dq_i),
        .raddr_i (idx_d),
        .rdata_o (buf_rdata)
    );

    // Control: state, word index, wait-state counter and latched request.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_we  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                idx_d  = '0;
                wait_d = '0;
                if (writeram) begin
                    state_d = ST_WR_ACCESS;
                    addr_d  = address_ram;
                    wdata_d = datatoram;
                end else if (readram) begin
                    state_d = ST_RD_FILL;
                    addr_d  = ADDR_W'(line_align(64'(address_ram), BURST_LOG2));
                end
            end
            ST_RD_FILL: begin
                if (wait_q == WAIT_LAST) begin
                    buf_we = 1'b1;
                    wait_d = '0;
                    idx_d  = idx_q + BURST_LOG2'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RD_STREAM;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_RD_STREAM: begin
                idx_d = idx_q + BURST_LOG2'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = ST_RECOVER;
                end
            end
            ST_WR_ACCESS: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = ST_WR_HOLD;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_WR_HOLD: state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes from a flop.
    always_comb begin
        ready_d  = 1'b0;
        dfr_d    = dfr_q;
        sram_a_d = sram_a_q;
        dq_o_d   = dq_o_q;
        dq_oe_d  = 1'b0;
        n_ce_d   = 1'b1;
        n_oe_d   = 1'b1;
        n_we_d   = 1'b1;
        unique case (state_d)
            ST_RD_FILL: begin
                sram_a_d = {addr_d[ADDR_W-1:BURST_LOG2], idx_d};
                n_ce_d   = 1'b0;
                n_oe_d   = 1'b0;
            end
            ST_RD_STREAM: begin
                ready_d = 1'b1;
                dfr_d   = buf_rdata;
            end
            ST_WR_ACCESS: begin
                sram_a_d = addr_d;
                dq_o_d   = wdata_d;
                dq_oe_d  = 1'b1;
                n_ce_d   = 1'b0;
                n_we_d   = 1'b0;
            end
            ST_WR_HOLD: begin
                sram_a_d = addr_d;
                dq_o_d   = wdata_d;
                dq_oe_d  = 1'b1;
                n_ce_d   = 1'b0;
                ready_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            wait_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ready_q  <= 1'b0;
            dfr_q    <= '0;
            sram_a_q <= '0;
            dq_o_q   <= '0;
            dq_oe_q  <= 1'b0;
            n_ce_q   <= 1'b1;
            n_oe_q   <= 1'b1;
            n_we_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wait_q   <= wait_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ready_q  <= ready_d;
            dfr_q    <= dfr_d;
            sram_a_q <= sram_a_d;
            dq_o_q   <= dq_o_d;
            dq_oe_q  <= dq_oe_d;
            n_ce_q   <= n_ce_d;
            n_oe_q   <= n_oe_d;
            n_we_q   <= n_we_d;
        end
    end

    assign ready       = ready_q;
    assign datafromram = dfr_q;
    assign sram_a      = sram_a_q;
    assign sram_dq_o   = dq_o_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_n_ce   = n_ce_q;
    assign sram_n_oe   = n_oe_q;
    assign sram_n_we   = n_we_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_responder.sv
`default_nettype none
// =============================================================================
// Module      : tb_ram_burst_responder
// Description : Self-checking bench: SRAM model, reference memory, scoreboard.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_ram_burst_responder;

    localparam int WS = 1;

    typedef struct {
        bit          wr;
        logic [15:0] data;
    } sb_t;

    typedef struct {
        bit          wr;
        logic [23:0] addr;
        logic [15:0] data;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [23:0] address_ram = '0;
    logic [15:0] datatoram = '0;
    logic        readram = 1'b0;
    logic        writeram = 1'b0;
    logic [15:0] datafromram;
    logic        ready;
    logic [23:0] sram_a;
    logic [15:0] sram_dq_o;
    logic [15:0] sram_dq_i;
    logic        sram_dq_oe, sram_n_ce, sram_n_oe, sram_n_we;

    logic [23:0] a_aux = '0;
    logic [15:0] d_aux = '0;
    logic        rd0 = 1'b0, rd3 = 1'b0, wr_aux = 1'b0;
    logic [15:0] dfr0, dfr3, dqo0, dqo3;
    logic        rdy0, rdy3, oe0, oe3, nce0, nce3, noe0, noe3, nwe0, nwe3;
    logic [23:0] sa0, sa3;

    int checks = 0;
    int errors = 0;
    int viol = 0;
    sb_t sb_q[$];
    sb_t mon_e;
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    always #5 clk = ~clk;

    ram_burst_responder #(.ADDR_W(24), .DATA_W(16), .BURST_LOG2(3), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .n_rst(n_rst), .address_ram(address_ram), .datatoram(datatoram),
        .readram(readram), .writeram(writeram), .datafromram(datafromram), .ready(ready),
        .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
        .sram_n_ce(sram_n_ce), .sram_n_oe(sram_n_oe), .sram_n_we(sram_n_we));

    ram_burst_responder #(.ADDR_W(24), .DATA_W(16), .BURST_LOG2(3), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .n_rst(n_rst), .address_ram(a_aux), .datatoram(d_aux),
        .readram(rd0), .writeram(wr_aux), .datafromram(dfr0), .ready(rdy0),
        .sram_a(sa0), .sram_dq_o(dqo0), .sram_dq_i(sa0[15:0]), .sram_dq_oe(oe0),
        .sram_n_ce(nce0), .sram_n_oe(noe0), .sram_n_we(nwe0));

    ram_burst_responder #(.ADDR_W(24), .DATA_W(16), .BURST_LOG2(3), .WAIT_STATES(3)) u_dut_ws3 (
        .clk(clk), .n_rst(n_rst), .address_ram(a_aux), .datatoram(d_aux),
        .readram(rd3), .writeram(wr_aux), .datafromram(dfr3), .ready(rdy3),
        .sram_a(sa3), .sram_dq_o(dqo3), .sram_dq_i(sa3[15:0]), .sram_dq_oe(oe3),
        .sram_n_ce(nce3), .sram_n_oe(noe3), .sram_n_we(nwe3));

    // Asynchronous SRAM model: unwritten words read back as their own low address bits.
    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i);
            ref_mem[i] = 16'(i);
        end
    end

    always @(posedge clk) begin
        if (!sram_n_ce && !sram_n_we && sram_dq_oe) begin
            mem[sram_a[15:0]] <= sram_dq_o;
        end
    end

    assign sram_dq_i = (!sram_n_ce && !sram_n_oe) ? mem[sram_a[15:0]] : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst && ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got ready with data 0x%0h expected no response", datafromram);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.wr) chk("wr_hold_data", 32'(sram_dq_o), 32'(mon_e.data));
                else          chk("rd_data", 32'(datafromram), 32'(mon_e.data));
            end
        end
    end

    always @(negedge clk) begin
        if (n_rst) begin
            if ((!sram_n_oe && !sram_n_we) || (!sram_n_oe && sram_dq_oe)) viol++;
            if ((!noe0 && !nwe0) || (!noe0 && oe0)) viol++;
            if ((!noe3 && !nwe3) || (!noe3 && oe3)) viol++;
        end
    end

    task automatic push_rd(input logic [23:0] a);
        sb_t e;
        for (int k = 0; k < 8; k++) begin
            e.wr   = 1'b0;
            e.data = ref_mem[{a[15:3], 3'(k)}];
            sb_q.push_back(e);
        end
    endtask

    task automatic push_wr(input logic [23:0] a, input logic [15:0] d);
        sb_t e;
        ref_mem[a[15:0]] = d;
        e.wr   = 1'b1;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // One complete transaction; lat is the first ready cycle, request cycle = 0.
    task automatic run_op(input bit wr, input logic [23:0] a, input logic [15:0] d,
                          input bit chk_addr, output int lat);
        int we_cnt;
        bit we_bad;
        int rcnt;
        logic [23:0] base;
        we_cnt = 0;
        we_bad = 1'b0;
        lat    = -1;
        base   = {a[23:3], 3'b000};
        if (wr) push_wr(a, d);
        else    push_rd(a);
        @(posedge clk); #1;
        address_ram = a;
        datatoram   = d;
        writeram    = wr;
        readram     = !wr;
        @(posedge clk);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (chk_addr && !wr && n <= 8*(WS+1) && ((n-1) % (WS+1)) == 0) begin
                chk("fill_addr", 32'(sram_a), 32'(base + 24'((n-1)/(WS+1))));
                chk("fill_strobes", 32'({sram_n_ce, sram_n_oe}), 32'(0));
            end
            if (wr && !sram_n_we) begin
                we_cnt++;
                if (sram_a !== a || sram_dq_o !== d || !sram_dq_oe) we_bad = 1'b1;
            end
            if (ready) begin
                lat = n;
                break;
            end
        end
        writeram = 1'b0;
        readram  = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: got no ready in 200 cycles expected a response");
        end else begin
            rcnt = 1;
            repeat (9) begin
                @(negedge clk);
                if (ready) rcnt++;
            end
            if (wr) begin
                chk("wr_ready_len", 32'(rcnt), 32'(1));
                chk("wr_we_cycles", 32'(we_cnt), 32'(WS+1));
                chk("wr_we_bus", 32'(we_bad), 32'(0));
            end else begin
                chk("rd_ready_len", 32'(rcnt), 32'(8));
            end
        end
    endtask

    initial begin
        vec_t vecs [10];
        int   lat, wlat, rlat, lat0, lat3, rcnt, act;
        bit   early_oe;

        vecs[0] = '{1'b1, 24'h001002, 16'hBEEF, 3};
        vecs[1] = '{1'b1, 24'h001007, 16'h1234, 3};
        vecs[2] = '{1'b0, 24'h001005, 16'h0000, 17};
        vecs[3] = '{1'b0, 24'h000000, 16'h0000, 17};
        vecs[4] = '{1'b1, 24'h00FFFF, 16'hFFFF, 3};
        vecs[5] = '{1'b0, 24'h00FFF9, 16'h0000, 17};
        vecs[6] = '{1'b1, 24'h000000, 16'h0001, 3};
        vecs[7] = '{1'b0, 24'h000007, 16'h0000, 17};
        vecs[8] = '{1'b1, 24'h123458, 16'hC3C3, 3};
        vecs[9] = '{1'b0, 24'h12345F, 16'h0000, 17};

        // Reset state and quiet idle.
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'(0));
        chk("rst_strobes", 32'({sram_n_ce, sram_n_oe, sram_n_we, sram_dq_oe}), 32'(4'b1110));
        chk("rst_addr_data", 32'({sram_a, 8'h00}) | 32'(datafromram), 32'(0));
        n_rst = 1'b1;
        act = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready || !sram_n_ce || !sram_n_oe || !sram_n_we || sram_dq_oe) act++;
        end
        chk("idle_activity", 32'(act), 32'(0));

        // Line fill of 0x000123 with address stepping checked.
        run_op(1'b0, 24'h000123, 16'h0000, 1'b1, lat);
        chk("rd_latency", 32'(lat), 32'(1 + 8*(WS+1)));

        // Word write then read-back of its line.
        run_op(1'b1, 24'h00ABCD, 16'h5A5A, 1'b0, lat);
        chk("wr_latency", 32'(lat), 32'(WS+2));
        chk("sram_model_word", 32'(mem[16'hABCD]), 32'(16'h5A5A));
        run_op(1'b0, 24'h00ABC8, 16'h0000, 1'b0, lat);

        // Simultaneous requests: write first, recover, then the still-held read.
        push_wr(24'h000345, 16'h7E7E);
        push_rd(24'h000345);
        @(posedge clk); #1;
        address_ram = 24'h000345;
        datatoram   = 16'h7E7E;
        writeram    = 1'b1;
        readram     = 1'b1;
        early_oe    = 1'b0;
        wlat = -1;
        rlat = -1;
        @(posedge clk);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (wlat < 0) begin
                if (!sram_n_oe) early_oe = 1'b1;
                if (ready) begin
                    wlat = n;
                    writeram = 1'b0;
                end
            end else if (ready) begin
                rlat = n;
                readram = 1'b0;
                break;
            end
        end
        writeram = 1'b0;
        readram  = 1'b0;
        chk("both_wr_first", 32'(wlat), 32'(WS+2));
        chk("both_no_read_before_wr", 32'(early_oe), 32'(0));
        chk("both_rd_after_recover", 32'(rlat), 32'((WS+2) + 2 + 1 + 8*(WS+1)));
        repeat (12) @(negedge clk);

        // Reset on the third ready cycle of a burst.
        push_rd(24'h000500);
        @(posedge clk); #1;
        address_ram = 24'h000500;
        readram     = 1'b1;
        rcnt = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (ready) begin
                readram = 1'b0;
                rcnt++;
                if (rcnt == 3) break;
            end
        end
        chk("midrst_reached", 32'(rcnt), 32'(3));
        #2;
        n_rst = 1'b0;
        #1;
        sb_q.delete();
        chk("midrst_ready", 32'(ready), 32'(0));
        chk("midrst_strobes", 32'({sram_n_ce, sram_n_oe, sram_n_we, sram_dq_oe}), 32'(4'b1110));
        chk("midrst_outputs", 32'(datafromram) | 32'({sram_a, 8'h00}), 32'(0));
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        run_op(1'b0, 24'h000508, 16'h0000, 1'b0, lat);
        chk("post_rst_rd_latency", 32'(lat), 32'(1 + 8*(WS+1)));

        // Table of mixed transactions.
        foreach (vecs[i]) begin
            run_op(vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0, lat);
            chk("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Wait-state variants: 0 and 3.
        lat0 = -1;
        lat3 = -1;
        @(posedge clk); #1;
        a_aux = 24'h000040;
        rd0   = 1'b1;
        rd3   = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (lat0 < 0 && rdy0) begin lat0 = n; rd0 = 1'b0; end
            if (lat3 < 0 && rdy3) begin lat3 = n; rd3 = 1'b0; end
            if (lat0 >= 0 && lat3 >= 0) break;
        end
        rd0 = 1'b0;
        rd3 = 1'b0;
        chk("ws0_latency", 32'(lat0), 32'(9));
        chk("ws3_latency", 32'(lat3), 32'(33));
        repeat (12) @(negedge clk);

        chk("strobe_overlap", 32'(viol), 32'(0));
        chk("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
